// File: rtl/multdiv_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_pkg
// Shared types and constants for the sequential multiply/divide unit.
//   md_state_e  : control FSM states (IDLE, MUL, DIV, FIX, DONE)
//   MD_WIDTH    : operand/result width (only 32 is supported)
//   MD_ITER     : number of shift/add iterations per operation
//   MD_INT_MIN  : most negative 32-bit value, the one quotient that overflows
// ---------------------------------------------------------------------------
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;

    localparam logic [MD_WIDTH-1:0] MD_INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } md_state_e;

endpackage : multdiv_pkg

// File: rtl/addsub_32.sv
// ---------------------------------------------------------------------------
// addsub_32
// The single adder/subtractor shared by Booth multiply, restoring divide and
// the final quotient negation.
//   a, b  in  32  operands
//   sub   in  1   0: a + b, 1: a + ~b + 1
//   sum   out 32  result
//   cout  out 1   carry out of bit 31 (no-borrow flag when subtracting)
// ---------------------------------------------------------------------------
module addsub_32
    import multdiv_pkg::*;
(
    input  logic [MD_WIDTH-1:0] a,
    input  logic [MD_WIDTH-1:0] b,
    input  logic                sub,
    output logic [MD_WIDTH-1:0] sum,
    output logic                cout
);

    logic [MD_WIDTH-1:0] b_eff;

    assign b_eff       = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{MD_WIDTH{1'b0}}, sub};

endmodule : addsub_32

// File: rtl/multdiv_seq.sv
// ---------------------------------------------------------------------------
// multdiv_seq
// Multi-cycle signed 32-bit multiply (radix-2 Booth) and divide (restoring,
// on magnitudes), both iterating through one shared addsub_32.
//
// Ports
//   clock           in  1   rising-edge clock
//   reset           in  1   synchronous, active-high reset
//   data_operandA   in  32  multiplicand / dividend
//   data_operandB   in  32  multiplier / divisor
//   ctrl_MULT       in  1   start multiply (wins over ctrl_DIV)
//   ctrl_DIV        in  1   start divide
//   data_result     out 32  low product word or quotient, held until next RDY
//   data_exception  out 1   mult overflow, div-by-zero or div overflow
//   data_resultRDY  out 1   one-cycle pulse when result/exception update
//
// Configuration
//   MULTDIV_DIV_EN  defined: divide path, FIX state and divide exceptions are
//                   built; undefined: ctrl_DIV is ignored, multiply only.
//
// Latency from the start edge E0: multiply RDY at E33, divide at E34,
// divide-by-zero at E1. Any start while busy restarts with new operands.
// ---------------------------------------------------------------------------
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [5:0] LAST_ITER = 6'(MD_ITER - 1);

    // Control and output registers
    md_state_e           state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [MD_WIDTH-1:0] result_q, result_d;
    logic                exc_q, exc_d;
    logic                rdy_q, rdy_d;

    // Datapath: A/remainder, Q/quotient, Booth q-1 bit, multiplicand/divisor
    logic [MD_WIDTH-1:0] a_q, a_d;
    logic [MD_WIDTH-1:0] q_q, q_d;
    logic                qm1_q, qm1_d;
    logic [MD_WIDTH-1:0] m_q, m_d;

    // Shared adder
    logic [MD_WIDTH-1:0] add_a, add_b, add_sum;
    logic                add_sub, add_cout;

    // Booth step helpers
    logic                booth_op;
    logic                mul_top;
    logic [MD_WIDTH-1:0] mul_acc;
    logic [MD_WIDTH:0]   prod_hi;
    logic                mul_ovf;

`ifdef MULTDIV_DIV_EN
    logic                sign_q, sign_d;
    logic                op_div_q, op_div_d;
    logic                dexc_q, dexc_d;
    logic                start_div;
    logic [MD_WIDTH-1:0] div_r;

    assign start_div = ctrl_DIV & ~ctrl_MULT;
    // Partial remainder shifted left with the next dividend bit. R is always
    // below |B| <= 2^31, so its top bit is zero and nothing is lost.
    assign div_r     = {a_q[MD_WIDTH-2:0], q_q[MD_WIDTH-1]};
`endif

    addsub_32 u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (add_sum),
        .cout(add_cout)
    );

    // Booth pair (Q[0], q-1): 01 adds M, 10 subtracts M, 00/11 only shift.
    assign booth_op = q_q[0] ^ qm1_q;
    assign mul_acc  = booth_op ? add_sum : a_q;
    // The true 33-bit sign of A +/- M: a 32-bit add overflows when M is
    // INT_MIN, so rebuild the sign from the operand signs and the carry.
    assign mul_top  = booth_op ? (a_q[MD_WIDTH-1] ^ (m_q[MD_WIDTH-1] ^ add_sub) ^ add_cout)
                               : a_q[MD_WIDTH-1];

    // Product fits in 32 bits only if its upper 33 bits are a sign extension.
    assign prod_hi  = {a_q, q_q[MD_WIDTH-1]};
    assign mul_ovf  = ~((&prod_hi) | ~(|prod_hi));

    // Adder input selection
    always_comb begin
        add_a   = a_q;
        add_b   = m_q;
        add_sub = q_q[0] & ~qm1_q;
`ifdef MULTDIV_DIV_EN
        if (start_div) begin
            // Any in-flight work is being discarded, so the start edge borrows
            // the adder to form the dividend magnitude (0 - A).
            add_a   = '0;
            add_b   = data_operandA;
            add_sub = 1'b1;
        end else if (state_q == DIV) begin
            // R' - |B| without negating B: subtract a positive divisor, add a
            // negative one. Either way cout=1 means R' >= |B|.
            add_a   = div_r;
            add_b   = m_q;
            add_sub = ~m_q[MD_WIDTH-1];
        end else if (state_q == FIX) begin
            add_a   = '0;
            add_b   = q_q;
            add_sub = 1'b1;
        end
`endif
    end

    // Next-state and datapath update
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        a_d      = a_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
`ifdef MULTDIV_DIV_EN
        sign_d   = sign_q;
        op_div_d = op_div_q;
        dexc_d   = dexc_q;
`endif

        if (ctrl_MULT) begin
            state_d  = MUL;
            cnt_d    = '0;
            a_d      = '0;
            q_d      = data_operandB;
            qm1_d    = 1'b0;
            m_d      = data_operandA;
`ifdef MULTDIV_DIV_EN
            op_div_d = 1'b0;
`endif
        end
`ifdef MULTDIV_DIV_EN
        else if (ctrl_DIV) begin
            cnt_d    = '0;
            a_d      = '0;
            m_d      = data_operandB;
            op_div_d = 1'b1;
            sign_d   = data_operandA[MD_WIDTH-1] ^ data_operandB[MD_WIDTH-1];
            dexc_d   = 1'b0;
            q_d      = data_operandA[MD_WIDTH-1] ? add_sum : data_operandA;
            if (data_operandB == '0) begin
                // Divide-by-zero is known at the start edge; skip straight to
                // DONE so RDY arrives one edge later.
                state_d = DONE;
                q_d     = '0;
                dexc_d  = 1'b1;
            end else begin
                state_d = DIV;
            end
        end
`endif
        else begin
            case (state_q)
                MUL: begin
                    // Arithmetic shift right of {A, Q, q-1}
                    a_d   = {mul_top, mul_acc[MD_WIDTH-1:1]};
                    q_d   = {mul_acc[0], q_q[MD_WIDTH-1:1]};
                    qm1_d = q_q[0];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end
`ifdef MULTDIV_DIV_EN
                DIV: begin
                    if (add_cout) begin
                        a_d = add_sum;
                        q_d = {q_q[MD_WIDTH-2:0], 1'b1};
                    end else begin
                        a_d = div_r;
                        q_d = {q_q[MD_WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = FIX;
                        cnt_d   = '0;
                    end
                end
                FIX: begin
                    q_d     = sign_q ? add_sum : q_q;
                    // Only INT_MIN / -1 yields an unsigned quotient of 2^31
                    // with a positive sign.
                    dexc_d  = ~sign_q & (q_q == MD_INT_MIN);
                    state_d = DONE;
                end
`endif
                DONE: begin
                    result_d = q_q;
`ifdef MULTDIV_DIV_EN
                    exc_d    = op_div_q ? dexc_q : mul_ovf;
`else
                    exc_d    = mul_ovf;
`endif
                    rdy_d    = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    // NOTE: datapath registers carry no reset; every operation loads them on
    // its start edge before they are read, so a reset would only add fan-out.
    always_ff @(posedge clock) begin
        a_q      <= a_d;
        q_q      <= q_d;
        qm1_q    <= qm1_d;
        m_q      <= m_d;
`ifdef MULTDIV_DIV_EN
        sign_q   <= sign_d;
        op_div_q <= op_div_d;
        dexc_q   <= dexc_d;
`endif
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule : multdiv_seq

// File: tb/tb_multdiv_seq.sv
// ---------------------------------------------------------------------------
// tb_multdiv_seq
// Self-checking bench for multdiv_seq: directed cases for reset, latency,
// exceptions, abort/restart and mid-operation reset, followed by random
// operations compared against an arithmetic reference model.
// Divide cases are built when MULTDIV_DIV_EN is defined; otherwise the bench
// checks that ctrl_DIV is ignored.
// ---------------------------------------------------------------------------
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV  = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    // Last value the outputs are required to hold
    logic [31:0] last_result = '0;
    logic        last_exc    = 1'b0;

    multdiv_seq #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: {exception, result} from plain signed arithmetic
    function automatic logic [32:0] model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q;
        if (!is_div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p != longint'($signed(p[31:0]))), p[31:0]};
        end
        if (b == 32'd0)
            return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Drive a start pulse; returns just after the sampling edge E0
    task automatic start(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        tick();
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Wait (bounded) for RDY; elapsed = edges already passed since E0
    task automatic wait_rdy(input string tag, input int elapsed, input int exp_lat, input logic [32:0] exp);
        int n    = elapsed;
        bit seen = 1'b0;
        bit held = 1'b1;
        while (n < 80 && !seen) begin
            tick();
            n++;
            if (data_resultRDY)
                seen = 1'b1;
            else if (data_result !== last_result || data_exception !== last_exc)
                held = 1'b0;
        end
        check({tag, " rdy seen"},     32'(seen), 32'd1);
        check({tag, " latency"},      32'(n), 32'(exp_lat));
        check({tag, " held before"},  32'(held), 32'd1);
        check({tag, " result"},       data_result, exp[31:0]);
        check({tag, " exception"},    32'(data_exception), 32'(exp[32]));
        tick();
        check({tag, " rdy one cycle"}, 32'(data_resultRDY), 32'd0);
        last_result = exp[31:0];
        last_exc    = exp[32];
    endtask

    // Require no RDY and unchanged outputs for a number of edges
    task automatic no_rdy(input string tag, input int cycles);
        bit quiet = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (data_resultRDY || data_result !== last_result || data_exception !== last_exc)
                quiet = 1'b0;
        end
        check({tag, " quiet"}, 32'(quiet), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 1000));
            2:       return -32'($urandom_range(1, 1000));
            default: return sp[$urandom_range(0, 4)];
        endcase
    endfunction

    initial begin
        logic        is_div;
        logic [31:0] ra, rb;
        int          lat;

        // Reset with a start pulse on the same edges: the start is ignored
        data_operandA = 32'd7;
        data_operandB = 32'd6;
        ctrl_MULT     = 1'b1;
        tick();
        tick();
        check("reset result",    data_result, 32'd0);
        check("reset exception", 32'(data_exception), 32'd0);
        check("reset rdy",       32'(data_resultRDY), 32'd0);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        no_rdy("start during reset", 40);

        // Basic multiplies
        start(1'b1, 1'b0, 32'd7, 32'd6);
        wait_rdy("mul 7x6", 0, 33, {1'b0, 32'd42});
        start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_rdy("mul ovf", 0, 33, {1'b1, 32'd0});
        start(1'b1, 1'b0, -32'd3, 32'd5);
        wait_rdy("mul -3x5", 0, 33, {1'b0, 32'hFFFF_FFF1});
        start(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_rdy("mul min*min", 0, 33, model(1'b0, 32'h8000_0000, 32'h8000_0000));

`ifdef MULTDIV_DIV_EN
        start(1'b0, 1'b1, -32'd7, 32'd2);
        wait_rdy("div -7/2", 0, 34, {1'b0, 32'hFFFF_FFFD});
        start(1'b0, 1'b1, 32'd100, -32'd7);
        wait_rdy("div 100/-7", 0, 34, {1'b0, 32'hFFFF_FFF2});
        start(1'b0, 1'b1, 32'd5, 32'd0);
        wait_rdy("div by zero", 0, 1, {1'b1, 32'd0});
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy("div min/-1", 0, 34, {1'b1, 32'h8000_0000});
        start(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_rdy("div min/min", 0, 34, {1'b0, 32'd1});
`else
        start(1'b0, 1'b1, 32'd100, 32'd7);
        no_rdy("div ignored", 40);
`endif

        // Abort a multiply with a divide at E10
        start(1'b1, 1'b0, 32'd3, 32'd4);
        no_rdy("abort pre", 9);
        start(1'b0, 1'b1, 32'd100, 32'd7);
`ifdef MULTDIV_DIV_EN
        wait_rdy("abort by div", 10, 44, {1'b0, 32'd14});
`else
        wait_rdy("div no abort", 10, 33, {1'b0, 32'd12});
`endif

        // Restart a multiply with another multiply at E10
        start(1'b1, 1'b0, 32'd3, 32'd4);
        no_rdy("restart pre", 9);
        start(1'b1, 1'b0, 32'd5, 32'd5);
        wait_rdy("mul restart", 10, 43, {1'b0, 32'd25});

        // Both pulses together: multiply wins
        start(1'b1, 1'b1, 32'd6, 32'd3);
        wait_rdy("both pulses", 0, 33, {1'b0, 32'd18});

        // Reset in the middle of a multiply
        start(1'b1, 1'b0, 32'h0000_1234, 32'd2);
        no_rdy("pre reset", 15);
        reset = 1'b1;
        tick();
        check("mid reset result",    data_result, 32'd0);
        check("mid reset exception", 32'(data_exception), 32'd0);
        check("mid reset rdy",       32'(data_resultRDY), 32'd0);
        reset       = 1'b0;
        last_result = '0;
        last_exc    = 1'b0;
        no_rdy("killed op", 40);

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
`ifdef MULTDIV_DIV_EN
            is_div = 1'($urandom_range(0, 1));
`else
            is_div = 1'b0;
`endif
            ra  = pick();
            rb  = pick();
            lat = !is_div ? 33 : (rb == 32'd0 ? 1 : 34);
            start(!is_div, is_div, ra, rb);
            wait_rdy($sformatf("rand%0d %s %h %h", i, is_div ? "div" : "mul", ra, rb),
                     0, lat, model(is_div, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multdiv_seq
